// File: rtl/uart_receiver_pkg.sv
// Shared UART definitions: bit-timing derivation, FSM state encoding and
// the ceiling-log2 helper used to size cycle counters.
package uart_receiver_pkg;

    // Character framing: 8N1.
    localparam int DATA_BITS = 8;

    // Ceiling log2; the counter must hold values 0 .. value-1.
    function automatic int log2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Clock cycles per bit on the line; shared with the transmitter.
    function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
        return clock_freq / baud_rate;
    endfunction

    // Offset from the start edge to the middle of the start bit.
    function automatic int sample_time(input int clock_freq, input int baud_rate);
        return symbol_edge_time(clock_freq, baud_rate) / 2;
    endfunction

    // Receiver FSM states; encoding fixed so it matches the transmitter's debug view.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_receiver_if.sv
// Ready/valid byte port between the UART receiver and its consumer.
interface uart_receiver_if;
    import uart_receiver_pkg::*;

    logic [DATA_BITS-1:0] data_out;
    logic                 data_out_valid;
    logic                 data_out_ready;

    // Receiver side: produces bytes.
    modport master (
        output data_out,
        output data_out_valid,
        input  data_out_ready
    );

    // Consumer side: accepts bytes.
    modport slave (
        input  data_out,
        input  data_out_valid,
        output data_out_ready
    );

endinterface

// File: rtl/uart_receiver_synchronizer.sv
// Two-stage synchronizer for asynchronous inputs, with a configurable
// reset value so idle-high lines do not look active coming out of reset.
module synchronizer #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] async_value,
    output logic [WIDTH-1:0] sync_value
);

    logic [WIDTH-1:0] stage1;
    logic [WIDTH-1:0] stage2;

    // Shift the asynchronous value through two flops to settle metastability.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so each flop samples the pre-edge value of its source.
        if (reset) begin
            stage1 <= RESET_VALUE;
            stage2 <= RESET_VALUE;
        end else begin
            stage1 <= async_value;
            stage2 <= stage1;
        end
    end

    assign sync_value = stage2;

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: synchronizes the RX pin, frames 8N1 characters by
// mid-bit sampling, and hands bytes out on a ready/valid port. Framing
// errors and overruns are reported as one-cycle pulses.
module uart_receiver
    import uart_receiver_pkg::*;
#(
    parameter int CLOCK_FREQ = 33_000_000,
    parameter int BAUD_RATE  = 115_200
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            serial_in,
    uart_receiver_if.master rx_bus,
    output logic            framing_error,
    output logic            overrun
);

    localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
    localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
    localparam int CNT_W            = log2(SYMBOL_EDGE_TIME);

    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_TIME - 1);
    localparam logic [CNT_W-1:0] SYMBOL_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [2:0]       LAST_BIT    = 3'(DATA_BITS - 1);

    logic                 rx_s;
    rx_state_e            state;
    logic [CNT_W-1:0]     cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] data_q;
    logic                 valid_q;

    synchronizer #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk         (clk),
        .reset       (reset),
        .async_value (serial_in),
        .sync_value  (rx_s)
    );

    // Framing FSM with registered byte, valid and error-pulse outputs.
    // The cycle counter free-runs and is cleared on every entry to a
    // state that times against it, so its value elsewhere is irrelevant.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            framing_error <= 1'b0;
            overrun       <= 1'b0;
            cnt           <= cnt + CNT_ONE;

            // Consumer handshake; a delivery on the same edge re-asserts valid below.
            if (valid_q && rx_bus.data_out_ready) begin
                valid_q <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state <= ST_START;
                        cnt   <= '0;
                    end
                end

                // Confirm the start bit at its midpoint; a high line means a glitch.
                ST_START: begin
                    if (cnt == SAMPLE_LAST) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                        end else begin
                            state   <= ST_DATA;
                            cnt     <= '0;
                            bit_idx <= '0;
                        end
                    end
                end

                // One full bit period after each midpoint lands on the next midpoint.
                ST_DATA: begin
                    if (cnt == SYMBOL_LAST) begin
                        shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end
                end

                // Stop-bit midpoint: deliver or flag; returning to IDLE here
                // leaves half a bit of margin before the next start edge.
                ST_STOP: begin
                    if (cnt == SYMBOL_LAST) begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                            if (!valid_q || rx_bus.data_out_ready) begin
                                data_q  <= shreg;
                                valid_q <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            framing_error <= 1'b1;
                            state         <= ST_BREAK;
                        end
                    end
                end

                // Held-low line after a bad stop bit: wait for it to return high.
                ST_BREAK: begin
                    if (rx_s) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rx_bus.data_out       = data_q;
    assign rx_bus.data_out_valid = valid_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: a table of directed frames, a few
// hand-written corner sequences and a randomized byte stream, all judged
// against timing and contents derived from the line protocol.
module tb_uart_receiver;

    localparam int CLOCK_FREQ   = 33_000_000;
    localparam int BAUD_RATE    = 115_200;
    localparam int SYM          = CLOCK_FREQ / BAUD_RATE;  // 286 cycles per bit
    localparam int HALF         = SYM / 2;                 // 143
    // Edge of the stop-bit sample, counted from edge 0 (first edge seeing low).
    localparam int STOP_LATENCY = 2 + HALF + 9 * SYM;

    logic clk       = 1'b0;
    logic reset     = 1'b1;
    logic serial_in = 1'b1;
    logic framing_error;
    logic overrun;

    uart_receiver_if bus ();

    uart_receiver #(
        .CLOCK_FREQ (CLOCK_FREQ),
        .BAUD_RATE  (BAUD_RATE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .serial_in     (serial_in),
        .rx_bus        (bus),
        .framing_error (framing_error),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Output monitor: logs each newly presented byte and each pulse with the
    // edge number after which it became visible.
    typedef struct {
        logic [7:0]  data;
        int unsigned at;
    } byte_ev_t;

    int unsigned edge_cnt = 0;
    byte_ev_t    got_q[$];
    int unsigned fe_at[$];
    int unsigned ov_at[$];
    int          valid_cycles = 0;
    logic        prev_valid   = 1'b0;
    logic        rdy_at_edge;

    always @(posedge clk) begin
        edge_cnt++;
        rdy_at_edge = bus.data_out_ready;
        #1;
        if (bus.data_out_valid && (!prev_valid || rdy_at_edge)) begin
            got_q.push_back('{bus.data_out, edge_cnt});
        end
        if (bus.data_out_valid) valid_cycles++;
        if (framing_error) fe_at.push_back(edge_cnt);
        if (overrun) ov_at.push_back(edge_cnt);
        prev_valid = bus.data_out_valid;
    end

    task automatic clear_log();
        got_q.delete();
        fe_at.delete();
        ov_at.delete();
        valid_cycles = 0;
    endtask

    // All drive tasks start and end at a falling edge.
    task automatic drive_bit(input logic v, input int n);
        serial_in = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, output int unsigned e0);
        e0 = edge_cnt + 1;
        drive_bit(1'b0, SYM);
        for (int i = 0; i < 8; i++) drive_bit(d[i], SYM);
        drive_bit(stop, SYM);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         low_bits;   // bit times the line is held low after the frame
        int         idle_bits;  // bit times of idle high after that
        logic       ready;
        int         exp_valid;
        int         exp_fe;
        int         exp_ov;
        logic [7:0] exp_dout;
    } vec_t;

    vec_t        vecs[8];
    int unsigned e0;
    int unsigned g0;
    byte_ev_t    exp_q[$];
    logic [7:0]  rbyte;
    logic [7:0]  partial;
    int          gap;

    initial begin
        // Single byte, framing error with break then recovery, back-to-back, overrun.
        vecs[0] = '{8'hA5, 1'b1, 0, 0, 1'b1, 1, 0, 0, 8'hA5};
        vecs[1] = '{8'h3C, 1'b0, 5, 1, 1'b1, 0, 1, 0, 8'hA5};
        vecs[2] = '{8'h3C, 1'b1, 0, 0, 1'b1, 1, 0, 0, 8'h3C};
        vecs[3] = '{8'h00, 1'b1, 0, 0, 1'b1, 1, 0, 0, 8'h00};
        vecs[4] = '{8'hFF, 1'b1, 0, 0, 1'b1, 1, 0, 0, 8'hFF};
        vecs[5] = '{8'h55, 1'b1, 0, 0, 1'b1, 1, 0, 0, 8'h55};
        vecs[6] = '{8'h11, 1'b1, 0, 0, 1'b0, 1, 0, 0, 8'h11};
        vecs[7] = '{8'h22, 1'b1, 0, 0, 1'b0, 0, 0, 1, 8'h11};

        bus.data_out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out", bus.data_out, 8'h00);
        check("reset_valid", bus.data_out_valid, 1'b0);
        check("reset_framing_error", framing_error, 1'b0);
        check("reset_overrun", overrun, 1'b0);
        reset = 1'b0;
        drive_bit(1'b1, 20);

        // Directed frame table.
        for (int i = 0; i < 8; i++) begin
            bus.data_out_ready = vecs[i].ready;
            clear_log();
            send_frame(vecs[i].data, vecs[i].stop, e0);
            if (vecs[i].low_bits > 0) drive_bit(1'b0, vecs[i].low_bits * SYM);
            if (vecs[i].idle_bits > 0) drive_bit(1'b1, vecs[i].idle_bits * SYM);
            check($sformatf("vec%0d_valid_count", i), got_q.size(), vecs[i].exp_valid);
            if (got_q.size() > 0) begin
                check($sformatf("vec%0d_byte", i), got_q[0].data, vecs[i].data);
                check($sformatf("vec%0d_valid_edge", i), got_q[0].at, e0 + STOP_LATENCY);
            end
            check($sformatf("vec%0d_fe_count", i), fe_at.size(), vecs[i].exp_fe);
            if (fe_at.size() > 0) check($sformatf("vec%0d_fe_edge", i), fe_at[0], e0 + STOP_LATENCY);
            check($sformatf("vec%0d_ov_count", i), ov_at.size(), vecs[i].exp_ov);
            if (ov_at.size() > 0) check($sformatf("vec%0d_ov_edge", i), ov_at[0], e0 + STOP_LATENCY);
            check($sformatf("vec%0d_data_out", i), bus.data_out, vecs[i].exp_dout);
            if (vecs[i].ready) check($sformatf("vec%0d_valid_cycles", i), valid_cycles, vecs[i].exp_valid);
        end

        // Overrun tail: byte still held, valid drops one cycle after ready rises.
        check("ovr_valid_held", bus.data_out_valid, 1'b1);
        bus.data_out_ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", bus.data_out_valid, 1'b0);
        check("ovr_data_hold", bus.data_out, 8'h11);

        // Reset during data bit 4 of 0x81; the sender abandons the frame.
        clear_log();
        partial = 8'h81;
        drive_bit(1'b0, SYM);
        for (int i = 0; i < 4; i++) drive_bit(partial[i], SYM);
        drive_bit(partial[4], HALF);
        reset     = 1'b1;
        serial_in = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_data_out", bus.data_out, 8'h00);
        check("rst_valid", bus.data_out_valid, 1'b0);
        check("rst_framing_error", framing_error, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        drive_bit(1'b1, 4 * SYM);
        check("rst_no_byte", got_q.size(), 0);
        check("rst_no_fe", fe_at.size(), 0);
        check("rst_no_ov", ov_at.size(), 0);
        clear_log();
        send_frame(8'h7E, 1'b1, e0);
        check("rst_next_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("rst_next_byte", got_q[0].data, 8'h7E);
            check("rst_next_edge", got_q[0].at, e0 + STOP_LATENCY);
        end

        // Glitch: 50 low cycles, then a real frame whose edge 0 is cycle 144
        // of the glitch, so the FSM must already be idle after edge 145.
        clear_log();
        g0 = edge_cnt + 1;
        drive_bit(1'b0, 50);
        drive_bit(1'b1, 94);
        check("glitch_no_byte", got_q.size(), 0);
        check("glitch_no_fe", fe_at.size(), 0);
        check("glitch_next_start", edge_cnt + 1 - g0, 144);
        send_frame(8'hC3, 1'b1, e0);
        check("glitch_next_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            check("glitch_next_byte", got_q[0].data, 8'hC3);
            check("glitch_next_edge", got_q[0].at, e0 + STOP_LATENCY);
        end
        check("glitch_next_fe", fe_at.size(), 0);

        // Random bytes with random idle gaps (often zero) against the line-level model.
        clear_log();
        exp_q.delete();
        for (int n = 0; n < 6; n++) begin
            rbyte = 8'($urandom);
            gap   = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 300));
            if (gap > 0) drive_bit(1'b1, gap);
            send_frame(rbyte, 1'b1, e0);
            exp_q.push_back('{rbyte, e0 + STOP_LATENCY});
        end
        drive_bit(1'b1, 10);
        check("rand_count", got_q.size(), exp_q.size());
        for (int n = 0; n < exp_q.size() && n < got_q.size(); n++) begin
            check($sformatf("rand%0d_byte", n), got_q[n].data, exp_q[n].data);
            check($sformatf("rand%0d_edge", n), got_q[n].at, exp_q[n].at);
        end
        check("rand_no_fe", fe_at.size(), 0);
        check("rand_no_ov", ov_at.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
